cc_goal_tracker: RTL and testbench
==================================

CC_GOAL_TRACKER -- requirements
Module: cc_goal_tracker

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, meaning the board row width in bits.
REQ-002 The block SHALL have parameter LIVES_INIT, default 3 (range 1..7), meaning the lives loaded at reset and at game start.
REQ-003 The block SHALL have parameter LEVEL_MAX, default 7 (range 1..7), meaning the saturation value of the level counter.
REQ-004 The block SHALL have parameter HOLD, default 2 (range 1..15), meaning the consecutive mismatch ticks needed to register a hit.
REQ-005 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-006 The block SHALL have port CC_GOALTRACKER_CLOCK_50, input, 1 bit: system clock, rising edge.
REQ-007 The block SHALL have port CC_GOALTRACKER_RESET_InLow, input, 1 bit: synchronous active-low reset.
REQ-008 The block SHALL have port CC_GOALTRACKER_tick_In, input, 1 bit: one-cycle evaluation strobe from the game timer.
REQ-009 The block SHALL have port CC_GOALTRACKER_start_In, input, 1 bit: game start request.
REQ-010 The block SHALL have port CC_GOALTRACKER_ack_In, input, 1 bit: board-cleared acknowledge from the game controller.
REQ-011 The block SHALL have port CC_GOALTRACKER_dataOR_InBUS, input, DATAWIDTH bits: OR of all lane registers.
REQ-012 The block SHALL have port CC_GOALTRACKER_dataLastRegister_InBUS, input, DATAWIDTH bits: goal-row register.
REQ-013 The block SHALL have port CC_GOALTRACKER_status_OutBUS, output, 2 bits: 00 level won, 10 hit, 11 playing, 01 idle/game over.
REQ-014 The block SHALL have ports CC_GOALTRACKER_lives_OutBUS and CC_GOALTRACKER_level_OutBUS, outputs, 3 bits each: lives remaining and current level.
REQ-015 The block SHALL have ports CC_GOALTRACKER_event_Out and CC_GOALTRACKER_clearRow_Out, outputs, 1 bit each: state-change pulse and board-clear request.

Function
REQ-016 The FSM SHALL have states IDLE, PLAY, WIN, HIT and OVER, with status 01, 11, 00, 10 and 01 respectively; all outputs SHALL be registered.
REQ-017 In IDLE or OVER, start_In=1 SHALL load lives=LIVES_INIT, level=0 and mismatch count=0, and SHALL move the FSM to PLAY.
REQ-018 In PLAY with tick_In=1, a row classified full (dataOR all ones across DATAWIDTH) SHALL move the FSM to WIN and set level=min(level+1, LEVEL_MAX); full SHALL take priority over mismatch.
REQ-019 In PLAY with tick_In=1 and dataOR != dataLastRegister, the mismatch count SHALL increment (saturating); reaching HOLD SHALL trigger a hit.
REQ-020 In PLAY with tick_In=1 and dataOR == dataLastRegister, the mismatch count SHALL clear to 0.
REQ-021 On a hit, lives SHALL decrement; if lives was 1, the FSM SHALL go to OVER with lives=0, otherwise to HIT.
REQ-022 In WIN or HIT, clearRow_Out SHALL be 1; ack_In=1 SHALL clear clearRow_Out, zero the mismatch count and return the FSM to PLAY.
REQ-023 Latency SHALL be as follows: the transition occurs on the edge sampling tick/start/ack; status, lives and level SHALL show the new values the next cycle; event_Out SHALL be 1 for exactly that one cycle.
REQ-024 tick_In SHALL be ignored outside PLAY, ack_In SHALL be ignored outside WIN/HIT, and start_In SHALL be ignored in PLAY, WIN and HIT.
REQ-025 When ack_In and tick_In are high together in WIN/HIT, only the ack SHALL act; the tick SHALL NOT be evaluated that cycle.
REQ-026 When lives=0 in OVER, no decrement SHALL occur (no underflow), and a level at LEVEL_MAX SHALL stay at LEVEL_MAX on WIN.

Reset
REQ-027 RESET_InLow=0 at a rising edge SHALL force state IDLE, status 01, lives=LIVES_INIT, level=0, event_Out=0, clearRow_Out=0 and mismatch count 0.
REQ-028 Reset SHALL dominate start, tick and ack in the same cycle, and SHALL abort any state mid-operation.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding and the status code constants (WIN=00, HIT=10, PLAY=11, IDLE/OVER=01).
REQ-030 The combinational row classifier (full/mismatch/equal, width DATAWIDTH) SHALL be the sub-module cc_row_classifier; the FSM and counters SHALL stay in cc_goal_tracker.

Verification
REQ-031 Reset, then start, then tick with OR=8'hFF SHALL give status 00, level=1, event pulse 1 cycle, clearRow=1; ack SHALL then give status 11.
REQ-032 OR=8'h10, Last=8'h00 on two consecutive ticks (HOLD=2) SHALL give status 10 and lives 3->2; a single mismatch tick followed by an equal tick SHALL cause no hit.
REQ-033 Three hits acked in turn SHALL end with lives=0 and status 01 (OVER); a further tick SHALL change nothing; start SHALL restore lives=3 and level=0.
REQ-034 Eight wins with LEVEL_MAX=7 SHALL hold level at 7; OR=8'hFF with Last!=OR SHALL still classify as a win.
REQ-035 ack and tick together in HIT SHALL return the FSM to PLAY with no hit evaluated; reset asserted in WIN SHALL give IDLE, status 01 and clearRow=0 the next cycle.
REQ-036 With DATAWIDTH=12, an OR of 12'hFFF SHALL classify as a win and 12'h0FF SHALL NOT.

Source files
------------

// File: rtl/cc_goal_tracker_pkg.sv
// Shared definitions for the goal tracker: FSM state encoding and the
// 2-bit status codes presented to the game controller.
package cc_goal_tracker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_WIN  = 3'd2,
    ST_HIT  = 3'd3,
    ST_OVER = 3'd4
  } state_t;

  localparam logic [1:0] STATUS_WIN  = 2'b00;
  localparam logic [1:0] STATUS_HIT  = 2'b10;
  localparam logic [1:0] STATUS_PLAY = 2'b11;
  localparam logic [1:0] STATUS_IDLE = 2'b01;  // also reported in OVER

  function automatic logic [1:0] statusOf(input state_t st);
    case (st)
      ST_PLAY: statusOf = STATUS_PLAY;
      ST_WIN:  statusOf = STATUS_WIN;
      ST_HIT:  statusOf = STATUS_HIT;
      default: statusOf = STATUS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cc_row_classifier.sv
// Combinational row classifier: compares the OR of all lanes against the
// goal row and flags a completely filled row.
module cc_row_classifier #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] dataOr,
  input  logic [DATAWIDTH-1:0] dataLast,
  output logic                 rowFull,
  output logic                 rowMismatch,
  output logic                 rowEqual
);

  assign rowFull     = &dataOr;
  assign rowEqual    = (dataOr == dataLast);
  assign rowMismatch = ~rowEqual;

endmodule

// File: rtl/cc_goal_tracker.sv
// Goal tracker FSM: counts consecutive mismatching ticks into hits, tracks
// lives and level, and requests a board clear on every win or hit.
module cc_goal_tracker
  import cc_goal_tracker_pkg::*;
#(
  parameter int DATAWIDTH  = 8,
  parameter int LIVES_INIT = 3,
  parameter int LEVEL_MAX  = 7,
  parameter int HOLD       = 2
) (
  input  logic                 CC_GOALTRACKER_CLOCK_50,
  input  logic                 CC_GOALTRACKER_RESET_InLow,
  input  logic                 CC_GOALTRACKER_tick_In,
  input  logic                 CC_GOALTRACKER_start_In,
  input  logic                 CC_GOALTRACKER_ack_In,
  input  logic [DATAWIDTH-1:0] CC_GOALTRACKER_dataOR_InBUS,
  input  logic [DATAWIDTH-1:0] CC_GOALTRACKER_dataLastRegister_InBUS,
  output logic [1:0]           CC_GOALTRACKER_status_OutBUS,
  output logic [2:0]           CC_GOALTRACKER_lives_OutBUS,
  output logic [2:0]           CC_GOALTRACKER_level_OutBUS,
  output logic                 CC_GOALTRACKER_event_Out,
  output logic                 CC_GOALTRACKER_clearRow_Out
);

  localparam logic [2:0] LIVES_RST = 3'(LIVES_INIT);
  localparam logic [2:0] LEVEL_TOP = 3'(LEVEL_MAX);
  localparam logic [3:0] HOLD_CNT  = 4'(HOLD);

  state_t     state;
  logic [3:0] missCnt;
  logic [3:0] missNext;
  logic       rowFull, rowMismatch, rowEqual;

  cc_row_classifier #(.DATAWIDTH(DATAWIDTH)) uClassifier (
    .dataOr      (CC_GOALTRACKER_dataOR_InBUS),
    .dataLast    (CC_GOALTRACKER_dataLastRegister_InBUS),
    .rowFull     (rowFull),
    .rowMismatch (rowMismatch),
    .rowEqual    (rowEqual)
  );

  assign missNext = (missCnt == 4'hF) ? missCnt : missCnt + 4'd1;

  always_ff @(posedge CC_GOALTRACKER_CLOCK_50) begin
    if (!CC_GOALTRACKER_RESET_InLow) begin
      state                        <= ST_IDLE;
      CC_GOALTRACKER_status_OutBUS <= statusOf(ST_IDLE);
      CC_GOALTRACKER_lives_OutBUS  <= LIVES_RST;
      CC_GOALTRACKER_level_OutBUS  <= 3'd0;
      CC_GOALTRACKER_event_Out     <= 1'b0;
      CC_GOALTRACKER_clearRow_Out  <= 1'b0;
      missCnt                      <= 4'd0;
    end else begin
      CC_GOALTRACKER_event_Out <= 1'b0;
      unique case (state)
        ST_IDLE, ST_OVER: begin
          if (CC_GOALTRACKER_start_In) begin
            state                        <= ST_PLAY;
            CC_GOALTRACKER_status_OutBUS <= statusOf(ST_PLAY);
            CC_GOALTRACKER_lives_OutBUS  <= LIVES_RST;
            CC_GOALTRACKER_level_OutBUS  <= 3'd0;
            CC_GOALTRACKER_event_Out     <= 1'b1;
            missCnt                      <= 4'd0;
          end
        end
        ST_PLAY: begin
          if (CC_GOALTRACKER_tick_In) begin
            // A full row wins even if it also differs from the goal row.
            if (rowFull) begin
              state                        <= ST_WIN;
              CC_GOALTRACKER_status_OutBUS <= statusOf(ST_WIN);
              CC_GOALTRACKER_clearRow_Out  <= 1'b1;
              CC_GOALTRACKER_event_Out     <= 1'b1;
              CC_GOALTRACKER_level_OutBUS  <= (CC_GOALTRACKER_level_OutBUS >= LEVEL_TOP) ?
                                              LEVEL_TOP : CC_GOALTRACKER_level_OutBUS + 3'd1;
            end else if (rowMismatch) begin
              missCnt <= missNext;
              if (missNext >= HOLD_CNT) begin
                CC_GOALTRACKER_event_Out <= 1'b1;
                if (CC_GOALTRACKER_lives_OutBUS <= 3'd1) begin
                  state                        <= ST_OVER;
                  CC_GOALTRACKER_status_OutBUS <= statusOf(ST_OVER);
                  CC_GOALTRACKER_lives_OutBUS  <= 3'd0;
                end else begin
                  state                        <= ST_HIT;
                  CC_GOALTRACKER_status_OutBUS <= statusOf(ST_HIT);
                  CC_GOALTRACKER_lives_OutBUS  <= CC_GOALTRACKER_lives_OutBUS - 3'd1;
                  CC_GOALTRACKER_clearRow_Out  <= 1'b1;
                end
              end
            end else if (rowEqual) begin
              missCnt <= 4'd0;
            end
          end
        end
        ST_WIN, ST_HIT: begin
          // Ack wins over a coincident tick; the tick is simply dropped.
          if (CC_GOALTRACKER_ack_In) begin
            state                        <= ST_PLAY;
            CC_GOALTRACKER_status_OutBUS <= statusOf(ST_PLAY);
            CC_GOALTRACKER_clearRow_Out  <= 1'b0;
            CC_GOALTRACKER_event_Out     <= 1'b1;
            missCnt                      <= 4'd0;
          end
        end
        default: begin
          state                        <= ST_IDLE;
          CC_GOALTRACKER_status_OutBUS <= statusOf(ST_IDLE);
          CC_GOALTRACKER_clearRow_Out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cc_goal_tracker.sv
// Scenario bench for cc_goal_tracker: expected output snapshots are queued as
// each cycle is driven and compared after the clock edge that produces them.
module tb_cc_goal_tracker;

  typedef struct packed {
    logic [1:0] status;
    logic [2:0] lives;
    logic [2:0] level;
    logic       evt;
    logic       clr;
  } obs_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0, tick = 1'b0, start = 1'b0, ack = 1'b0;
  logic [7:0]  orBus = 8'h00, lastBus = 8'h00;
  logic [11:0] or12 = 12'h000, last12 = 12'h000;

  logic [1:0] status, status12;
  logic [2:0] lives, level, lives12, level12;
  logic       evt, clr, evt12, clr12;

  obs_t expQ[$];
  obs_t exp;
  int   errors = 0;
  int   checks = 0;

  always #10 clk = ~clk;

  cc_goal_tracker dut (
    .CC_GOALTRACKER_CLOCK_50               (clk),
    .CC_GOALTRACKER_RESET_InLow            (rstN),
    .CC_GOALTRACKER_tick_In                (tick),
    .CC_GOALTRACKER_start_In               (start),
    .CC_GOALTRACKER_ack_In                 (ack),
    .CC_GOALTRACKER_dataOR_InBUS           (orBus),
    .CC_GOALTRACKER_dataLastRegister_InBUS (lastBus),
    .CC_GOALTRACKER_status_OutBUS          (status),
    .CC_GOALTRACKER_lives_OutBUS           (lives),
    .CC_GOALTRACKER_level_OutBUS           (level),
    .CC_GOALTRACKER_event_Out              (evt),
    .CC_GOALTRACKER_clearRow_Out           (clr)
  );

  cc_goal_tracker #(.DATAWIDTH(12)) dut12 (
    .CC_GOALTRACKER_CLOCK_50               (clk),
    .CC_GOALTRACKER_RESET_InLow            (rstN),
    .CC_GOALTRACKER_tick_In                (tick),
    .CC_GOALTRACKER_start_In               (start),
    .CC_GOALTRACKER_ack_In                 (ack),
    .CC_GOALTRACKER_dataOR_InBUS           (or12),
    .CC_GOALTRACKER_dataLastRegister_InBUS (last12),
    .CC_GOALTRACKER_status_OutBUS          (status12),
    .CC_GOALTRACKER_lives_OutBUS           (lives12),
    .CC_GOALTRACKER_level_OutBUS           (level12),
    .CC_GOALTRACKER_event_Out              (evt12),
    .CC_GOALTRACKER_clearRow_Out           (clr12)
  );

  obs_t obsNow, obs12;
  assign obsNow = '{status, lives, level, evt, clr};
  assign obs12  = '{status12, lives12, level12, evt12, clr12};

  // Drive one cycle of inputs, queue the expected post-edge snapshot, and
  // leave the simulation just after the edge so outputs can be sampled.
  task automatic cyc(input logic r, input logic t, input logic s, input logic a,
                     input logic [7:0] o, input logic [7:0] l, input obs_t e);
    rstN = r; tick = t; start = s; ack = a; orBus = o; lastBus = l;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    rstN = 1'b1; tick = 1'b0; start = 1'b0; ack = 1'b0;
  endtask

  task automatic test_reset();
    cyc(0, 1, 1, 1, 8'hFF, 8'h00, '{2'b01, 3'd3, 3'd0, 1'b0, 1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL reset got=%h exp=%h", obsNow, exp); end
  endtask

  task automatic test_win();
    obs_t seq[5];
    seq = '{'{2'b11,3'd3,3'd0,1'b1,1'b0}, '{2'b00,3'd3,3'd1,1'b1,1'b1},
            '{2'b00,3'd3,3'd1,1'b0,1'b1}, '{2'b11,3'd3,3'd1,1'b1,1'b0},
            '{2'b11,3'd3,3'd1,1'b0,1'b0}};
    cyc(1, 0, 1, 0, 8'h00, 8'h00, seq[0]);
    cyc(1, 1, 0, 0, 8'hFF, 8'h00, seq[1]);
    cyc(1, 0, 0, 0, 8'hFF, 8'h00, seq[2]);
    cyc(1, 0, 0, 1, 8'h00, 8'h00, seq[3]);
    cyc(1, 0, 0, 0, 8'h00, 8'h00, seq[4]);
    for (int i = 0; i < 5; i++) begin
      exp = expQ.pop_front(); checks++;
      if (exp !== seq[i]) begin errors++; $display("FAIL win_queue step=%0d", i); end
    end
    // Re-run the comparisons against the live trace recorded below.
  endtask

  task automatic test_hit();
    cyc(1, 1, 0, 0, 8'h10, 8'h00, '{2'b11,3'd3,3'd1,1'b0,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL hit_miss1 got=%h exp=%h", obsNow, exp); end
    cyc(1, 1, 0, 0, 8'h10, 8'h10, '{2'b11,3'd3,3'd1,1'b0,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL hit_equal got=%h exp=%h", obsNow, exp); end
    cyc(1, 1, 0, 0, 8'h10, 8'h00, '{2'b11,3'd3,3'd1,1'b0,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL hit_after_clear got=%h exp=%h", obsNow, exp); end
    cyc(1, 0, 0, 0, 8'h10, 8'h00, '{2'b11,3'd3,3'd1,1'b0,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL hit_notick got=%h exp=%h", obsNow, exp); end
    cyc(1, 1, 0, 0, 8'h10, 8'h00, '{2'b10,3'd2,3'd1,1'b1,1'b1});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL hit_taken got=%h exp=%h", obsNow, exp); end
    cyc(1, 1, 0, 0, 8'h10, 8'h00, '{2'b10,3'd2,3'd1,1'b0,1'b1});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL hit_tick_ignored got=%h exp=%h", obsNow, exp); end
    cyc(1, 0, 0, 1, 8'h00, 8'h00, '{2'b11,3'd2,3'd1,1'b1,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL hit_ack got=%h exp=%h", obsNow, exp); end
  endtask

  task automatic test_ack_tick();
    cyc(1, 1, 0, 0, 8'h10, 8'h00, '{2'b11,3'd2,3'd1,1'b0,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL at_miss1 got=%h exp=%h", obsNow, exp); end
    cyc(1, 1, 0, 0, 8'h10, 8'h00, '{2'b10,3'd1,3'd1,1'b1,1'b1});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL at_hit2 got=%h exp=%h", obsNow, exp); end
    cyc(1, 1, 0, 1, 8'h10, 8'h00, '{2'b11,3'd1,3'd1,1'b1,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL at_ack_and_tick got=%h exp=%h", obsNow, exp); end
    cyc(1, 1, 0, 0, 8'h10, 8'h00, '{2'b11,3'd1,3'd1,1'b0,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL at_count_zeroed got=%h exp=%h", obsNow, exp); end
    cyc(1, 1, 0, 0, 8'h10, 8'h00, '{2'b01,3'd0,3'd1,1'b1,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL at_game_over got=%h exp=%h", obsNow, exp); end
  endtask

  task automatic test_over();
    cyc(1, 1, 0, 0, 8'hFF, 8'h00, '{2'b01,3'd0,3'd1,1'b0,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL over_tick_full got=%h exp=%h", obsNow, exp); end
    cyc(1, 1, 0, 1, 8'h10, 8'h00, '{2'b01,3'd0,3'd1,1'b0,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL over_tick_miss got=%h exp=%h", obsNow, exp); end
    cyc(1, 0, 1, 0, 8'h00, 8'h00, '{2'b11,3'd3,3'd0,1'b1,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL over_restart got=%h exp=%h", obsNow, exp); end
  endtask

  task automatic test_start_ignored();
    cyc(1, 0, 1, 1, 8'h00, 8'h00, '{2'b11,3'd3,3'd0,1'b0,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL play_start_ack got=%h exp=%h", obsNow, exp); end
  endtask

  task automatic test_level_sat();
    logic [2:0] lvl;
    lvl = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 0, 0, 8'h10, 8'h00, '{2'b11,3'd3,lvl,1'b0,1'b0});
      exp = expQ.pop_front(); checks++;
      if (obsNow !== exp) begin errors++; $display("FAIL lvl_pre_miss i=%0d got=%h exp=%h", i, obsNow, exp); end
      lvl = (lvl == 3'd7) ? 3'd7 : lvl + 3'd1;
      // Full row with a differing goal row and a pending mismatch: still a win.
      cyc(1, 1, 0, 0, 8'hFF, 8'h00, '{2'b00,3'd3,lvl,1'b1,1'b1});
      exp = expQ.pop_front(); checks++;
      if (obsNow !== exp) begin errors++; $display("FAIL lvl_win i=%0d got=%h exp=%h", i, obsNow, exp); end
      if (i == 0) begin
        cyc(1, 1, 1, 0, 8'hFF, 8'h00, '{2'b00,3'd3,lvl,1'b0,1'b1});
        exp = expQ.pop_front(); checks++;
        if (obsNow !== exp) begin errors++; $display("FAIL win_ignores got=%h exp=%h", obsNow, exp); end
      end
      cyc(1, 0, 0, 1, 8'h00, 8'h00, '{2'b11,3'd3,lvl,1'b1,1'b0});
      exp = expQ.pop_front(); checks++;
      if (obsNow !== exp) begin errors++; $display("FAIL lvl_ack i=%0d got=%h exp=%h", i, obsNow, exp); end
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 1, 0, 0, 8'hFF, 8'h00, '{2'b00,3'd3,3'd7,1'b1,1'b1});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL mid_win got=%h exp=%h", obsNow, exp); end
    cyc(0, 1, 1, 1, 8'hFF, 8'h00, '{2'b01,3'd3,3'd0,1'b0,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL mid_reset got=%h exp=%h", obsNow, exp); end
    cyc(1, 1, 0, 1, 8'hFF, 8'h00, '{2'b01,3'd3,3'd0,1'b0,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL idle_ignores got=%h exp=%h", obsNow, exp); end
  endtask

  task automatic test_wide();
    cyc(0, 0, 0, 0, 8'h00, 8'h00, '{2'b01,3'd3,3'd0,1'b0,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obs12 !== exp) begin errors++; $display("FAIL w12_reset got=%h exp=%h", obs12, exp); end
    cyc(1, 0, 1, 0, 8'h00, 8'h00, '{2'b11,3'd3,3'd0,1'b1,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obs12 !== exp) begin errors++; $display("FAIL w12_start got=%h exp=%h", obs12, exp); end
    or12 = 12'h0FF; last12 = 12'h0FF;
    cyc(1, 1, 0, 0, 8'h00, 8'h00, '{2'b11,3'd3,3'd0,1'b0,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obs12 !== exp) begin errors++; $display("FAIL w12_partial got=%h exp=%h", obs12, exp); end
    or12 = 12'hFFF; last12 = 12'h0FF;
    cyc(1, 1, 0, 0, 8'h00, 8'h00, '{2'b00,3'd3,3'd1,1'b1,1'b1});
    exp = expQ.pop_front(); checks++;
    if (obs12 !== exp) begin errors++; $display("FAIL w12_full got=%h exp=%h", obs12, exp); end
  endtask

  // Live trace of the win scenario, compared inline against constants.
  task automatic test_win_trace();
    cyc(1, 0, 1, 0, 8'h00, 8'h00, '{2'b11,3'd3,3'd0,1'b1,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL win_start got=%h exp=%h", obsNow, exp); end
    cyc(1, 1, 0, 0, 8'hFF, 8'h00, '{2'b00,3'd3,3'd1,1'b1,1'b1});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL win_tick got=%h exp=%h", obsNow, exp); end
    cyc(1, 0, 0, 0, 8'hFF, 8'h00, '{2'b00,3'd3,3'd1,1'b0,1'b1});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL win_event_drop got=%h exp=%h", obsNow, exp); end
    cyc(1, 0, 0, 1, 8'h00, 8'h00, '{2'b11,3'd3,3'd1,1'b1,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL win_ack got=%h exp=%h", obsNow, exp); end
    cyc(1, 0, 0, 0, 8'h00, 8'h00, '{2'b11,3'd3,3'd1,1'b0,1'b0});
    exp = expQ.pop_front(); checks++;
    if (obsNow !== exp) begin errors++; $display("FAIL win_settle got=%h exp=%h", obsNow, exp); end
  endtask

  initial begin
    #5;
    test_reset();
    test_win_trace();
    test_hit();
    test_ack_tick();
    test_over();
    test_start_ignored();
    test_level_sat();
    test_reset_mid();
    test_wide();
    if (expQ.size() != 0) begin
      errors++; $display("FAIL queue_leftover got=%0d exp=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
